// File: rtl/fetch_pkg.sv
// Shared definitions for the fetch stage: state encoding, default widths
// and the bubble instruction word.
package fetch_pkg;

  localparam int FETCH_PC_WIDTH    = 8;
  localparam int FETCH_INSTR_WIDTH = 32;

  // Bubble / NOP word written into the IF/ID latch when it is invalidated.
  localparam logic [FETCH_INSTR_WIDTH-1:0] FETCH_NOP = '0;

  typedef enum logic {
    RUN    = 1'b0,
    HALTED = 1'b1
  } fetch_state_t;

endpackage

// File: rtl/fetch_if_id_reg.sv
// IF/ID pipeline latch. Captures the fetched instruction and its successor
// PC on the falling edge of clock.
//   clock, reset     stage clock (falling edge), synchronous active-high reset
//   flush            invalidate the latch (flush or branch redirect)
//   hold             stall: keep all three outputs
//   bubble           fetch is halted: emit an invalid, all-zero instruction
//   instrIn          instruction word for the current fetch address
//   pcNextIn         fetch address + step, travels with the instruction
//   instrOut, pcNextOut, validOut   latched values to decode
module fetch_if_id_reg
  import fetch_pkg::*;
#(
  parameter int PC_WIDTH    = FETCH_PC_WIDTH,
  parameter int INSTR_WIDTH = FETCH_INSTR_WIDTH
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   flush,
  input  logic                   hold,
  input  logic                   bubble,
  input  logic [INSTR_WIDTH-1:0] instrIn,
  input  logic [PC_WIDTH-1:0]    pcNextIn,
  output logic [INSTR_WIDTH-1:0] instrOut,
  output logic [PC_WIDTH-1:0]    pcNextOut,
  output logic                   validOut
);

  localparam logic [INSTR_WIDTH-1:0] NOP = INSTR_WIDTH'(FETCH_NOP);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of statement order.
  always_ff @(negedge clock) begin
    if (reset) begin
      instrOut  <= NOP;
      pcNextOut <= '0;
      validOut  <= 1'b0;
    end else if (flush) begin
      instrOut  <= NOP;
      pcNextOut <= '0;
      validOut  <= 1'b0;
    end else if (hold) begin
      // NOTE: a branch with no assignment inside a clocked block is a
      // register enable, not a latch; the flops simply keep their value.
    end else if (bubble) begin
      // pcNextOut is meaningless while validOut=0, so it is left as is.
      instrOut <= NOP;
      validOut <= 1'b0;
    end else begin
      instrOut  <= instrIn;
      pcNextOut <= pcNextIn;
      validOut  <= 1'b1;
    end
  end

endmodule

// File: rtl/fetch_pc_unit.sv
// Fetch stage: PC register, next-PC selection, RUN/HALTED control and the
// IF/ID latch. All state changes on the falling edge of clock.
//   clock, reset          stage clock, synchronous active-high reset
//   notEnable             stall from the hazard unit (holds PC and IF/ID)
//   branchTaken/Target    redirect; wins over stall and halt
//   flush                 invalidate IF/ID only
//   halt, resume          enter / leave HALTED
//   instrIn               instruction memory data for pcOut
//   pcOut                 fetch address
//   pcNextOut, instrOut, validOut   IF/ID contents to decode
//   halted                1 while in HALTED
module fetch_pc_unit
  import fetch_pkg::*;
#(
  parameter int          PC_WIDTH    = FETCH_PC_WIDTH,
  parameter int          INSTR_WIDTH = FETCH_INSTR_WIDTH,
  parameter int unsigned RESET_PC    = 0,
  parameter int unsigned PC_STEP     = 1
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   notEnable,
  input  logic                   branchTaken,
  input  logic [PC_WIDTH-1:0]    branchTarget,
  input  logic                   flush,
  input  logic                   halt,
  input  logic                   resume,
  input  logic [INSTR_WIDTH-1:0] instrIn,
  output logic [PC_WIDTH-1:0]    pcOut,
  output logic [PC_WIDTH-1:0]    pcNextOut,
  output logic [INSTR_WIDTH-1:0] instrOut,
  output logic                   validOut,
  output logic                   halted
);

  localparam logic [PC_WIDTH-1:0] PC_RESET_VAL = RESET_PC[PC_WIDTH-1:0];
  localparam logic [PC_WIDTH-1:0] PC_INC       = PC_STEP[PC_WIDTH-1:0];

  fetch_state_t        state, state_next;
  logic [PC_WIDTH-1:0] pc_inc, pc_next;
  logic                in_halt;

  // ---------------- state machine ----------------
  always_ff @(negedge clock) begin
    if (reset) state <= RUN;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      RUN:     if (halt)   state_next = HALTED;
      HALTED:  if (resume) state_next = RUN;
      default: state_next = RUN;
    endcase
  end

  always_comb begin
    in_halt = (state == HALTED);
    halted  = in_halt;
  end

  // ---------------- PC ----------------
  // Wraps modulo 2^PC_WIDTH through natural truncation.
  assign pc_inc = pcOut + PC_INC;

  // The halt request edge still increments: the hold keys off the current
  // state, not the halt input.
  always_comb begin
    pc_next = pc_inc;
    if (branchTaken)               pc_next = branchTarget;
    else if (in_halt || notEnable) pc_next = pcOut;
  end

  always_ff @(negedge clock) begin
    if (reset) pcOut <= PC_RESET_VAL;
    else       pcOut <= pc_next;
  end

  // ---------------- IF/ID latch ----------------
  fetch_if_id_reg #(
    .PC_WIDTH    (PC_WIDTH),
    .INSTR_WIDTH (INSTR_WIDTH)
  ) u_if_id (
    .clock     (clock),
    .reset     (reset),
    .flush     (flush | branchTaken),
    .hold      (notEnable),
    .bubble    (in_halt),
    .instrIn   (instrIn),
    .pcNextIn  (pc_inc),
    .instrOut  (instrOut),
    .pcNextOut (pcNextOut),
    .validOut  (validOut)
  );

endmodule

// File: tb/tb_fetch_pc_unit.sv
module tb_fetch_pc_unit;

  localparam int PW = 8;
  localparam int IW = 32;

  logic          clock = 1'b1;
  logic          reset = 1'b1;
  logic          notEnable = 1'b0, branchTaken = 1'b0, flush = 1'b0;
  logic          halt = 1'b0, resume = 1'b0;
  logic [PW-1:0] branchTarget = '0;
  logic [IW-1:0] instrIn;
  logic [PW-1:0] pcOut, pcNextOut;
  logic [IW-1:0] instrOut;
  logic          validOut, halted;

  always #5 clock = ~clock;

  fetch_pc_unit dut (
    .clock        (clock),
    .reset        (reset),
    .notEnable    (notEnable),
    .branchTaken  (branchTaken),
    .branchTarget (branchTarget),
    .flush        (flush),
    .halt         (halt),
    .resume       (resume),
    .instrIn      (instrIn),
    .pcOut        (pcOut),
    .pcNextOut    (pcNextOut),
    .instrOut     (instrOut),
    .validOut     (validOut),
    .halted       (halted)
  );

  // Instruction memory: combinational read at the fetch address.
  logic [IW-1:0] mem [256];
  always_comb instrIn = mem[pcOut];

  typedef struct {
    int          pc;
    int          pcn;
    bit          pcn_chk;
    logic [31:0] instr;
    bit          valid;
    bit          hlt;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  // Reference model state (architectural view of the fetch stage).
  int          m_pc = 0, m_pcn = 0;
  bit          m_pcn_known = 1'b1;
  logic [31:0] m_instr = '0;
  bit          m_valid = 1'b0, m_halted = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got 0x%0h, expected 0x%0h", name, $time, act, exp);
    end
  endtask

  // One stage cycle: drive inputs after the rising edge, predict the result
  // of the coming falling edge, queue it once that edge has happened.
  task automatic cyc(input bit rst, input bit ne, input bit br, input int tgt,
                     input bit fl, input bit h, input bit r);
    exp_t e;
    int   old_pc;
    bit   was_halted;
    @(posedge clock);
    reset = rst; notEnable = ne; branchTaken = br; branchTarget = tgt[PW-1:0];
    flush = fl; halt = h; resume = r;
    if (rst) begin
      m_pc = 0; m_pcn = 0; m_pcn_known = 1; m_instr = '0; m_valid = 0; m_halted = 0;
    end else begin
      old_pc     = m_pc;
      was_halted = m_halted;
      if (br)                      m_pc = tgt % 256;
      else if (!was_halted && !ne) m_pc = (old_pc + 1) % 256;
      if (fl || br) begin
        m_valid = 0; m_instr = '0; m_pcn = 0; m_pcn_known = 1;
      end else if (ne) begin
        // stalled: decode keeps what it had
      end else if (was_halted) begin
        m_valid = 0; m_instr = '0; m_pcn_known = 0;
      end else begin
        m_valid = 1; m_instr = mem[old_pc]; m_pcn = (old_pc + 1) % 256; m_pcn_known = 1;
      end
      m_halted = was_halted ? !r : h;
    end
    e.pc = m_pc; e.pcn = m_pcn; e.pcn_chk = m_pcn_known;
    e.instr = m_instr; e.valid = m_valid; e.hlt = m_halted;
    @(negedge clock);
    sb.push_back(e);
  endtask

  task automatic free(input int n);
    for (int i = 0; i < n; i++) cyc(0, 0, 0, 0, 0, 0, 0);
  endtask

  // Monitor: outputs are stable between falling edges; sample on the rising one.
  exp_t got;
  initial begin
    forever begin
      @(posedge clock);
      if (sb.size() > 0) begin
        got = sb.pop_front();
        check("pcOut",    32'(pcOut),    32'(got.pc));
        check("validOut", 32'(validOut), 32'(got.valid));
        check("instrOut", instrOut,      got.instr);
        check("halted",   32'(halted),   32'(got.hlt));
        if (got.pcn_chk) check("pcNextOut", 32'(pcNextOut), 32'(got.pcn));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = $urandom;

    cyc(1, 0, 0, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 0, 0, 0);
    free(5);                          // pc 1..5, IF/ID holds mem[0..4]
    cyc(0, 1, 0, 0, 0, 0, 0);         // stall at pc 5
    cyc(0, 1, 0, 0, 0, 0, 0);
    free(2);                          // pc 6, 7
    cyc(0, 1, 1, 'h40, 0, 0, 0);      // branch overrides stall
    free(2);                          // mem[0x40] arrives
    cyc(0, 0, 0, 0, 1, 0, 0);         // flush only kills IF/ID
    cyc(0, 0, 1, 10, 0, 0, 0);        // go to pc 10
    cyc(0, 0, 0, 0, 0, 1, 0);         // halt edge still increments
    free(2);                          // frozen, bubbles
    cyc(0, 0, 0, 0, 0, 0, 1);         // resume
    free(2);
    cyc(0, 0, 1, 254, 0, 0, 0);       // wrap region
    free(4);                          // 255, 0, 1, 2
    cyc(0, 0, 0, 0, 0, 1, 0);
    cyc(0, 0, 1, 'h33, 0, 0, 0);      // branch while halted
    cyc(0, 0, 0, 0, 0, 0, 0);
    cyc(1, 1, 1, 'h77, 1, 1, 0);      // reset wins over everything
    free(2);

    for (int i = 0; i < 400; i++)
      cyc(($urandom_range(63) == 0), ($urandom_range(3) == 0), ($urandom_range(7) == 0),
          int'($urandom_range(255)), ($urandom_range(7) == 0), ($urandom_range(15) == 0),
          ($urandom_range(3) == 0));

    for (int i = 0; i < 10 && sb.size() > 0; i++) @(negedge clock);
    if (sb.size() > 0) check("scoreboard_drain", 32'(sb.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
